// File: rtl/match_reporter_if.sv
// match_reporter_if: batch-in / ID-out stream bundle for match_reporter.
//   batch_valid/batch_ready/batch_hits/batch_base/batch_count : per-pass result batch
//   out_valid/out_ready/out_id/out_last                       : sparse match-ID stream
//   batch_done                                                : one-cycle batch-complete pulse
//   hit_total                                                 : saturating delivered-ID count
// slave = the reporter, master = the producer/consumer side driving it.
interface match_reporter_if #(
  parameter int unsigned NPE = 256,
  parameter int unsigned IDW = 15,
  parameter int unsigned CW  = 9
) ();
  logic           batch_valid;
  logic           batch_ready;
  logic [NPE-1:0] batch_hits;
  logic [IDW-1:0] batch_base;
  logic [CW-1:0]  batch_count;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_id;
  logic           out_last;
  logic           batch_done;
  logic [15:0]    hit_total;

  modport slave (
    input  batch_valid, batch_hits, batch_base, batch_count, out_ready,
    output batch_ready, out_valid, out_id, out_last, batch_done, hit_total
  );

  modport master (
    output batch_valid, batch_hits, batch_base, batch_count, out_ready,
    input  batch_ready, out_valid, out_id, out_last, batch_done, hit_total
  );
endinterface

// File: rtl/match_reporter.sv
// match_reporter: accepts one NPE-bit match vector per pass and streams the
// global weight ID (base + PE index) of every hit, lowest PE first.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : match_reporter_if.slave (batch input, ID stream, done pulse, hit count)
module match_reporter #(
  parameter int unsigned groups     = 16,
  parameter int unsigned num        = 16,
  parameter int unsigned weight_num = 23331,
  parameter int unsigned NPE        = groups * num,
  parameter int unsigned IDW        = $clog2(weight_num),
  parameter int unsigned CW         = $clog2(NPE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  match_reporter_if.slave   bus
);

  localparam int unsigned IXW = (NPE > 1) ? $clog2(NPE) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [NPE-1:0] r_pend;
  logic [IDW-1:0] r_base;
  logic           r_batch_done;
  logic [15:0]    r_hit_total;

  logic [NPE-1:0] w_mask;
  logic [NPE-1:0] w_hits_m;
  logic [NPE-1:0] w_pend_rest;
  logic [IXW-1:0] w_idx;
  logic           w_accept;
  logic           w_beat;
  logic           w_batch_ready;
  logic           w_out_valid;
  logic [IDW-1:0] w_out_id;
  logic           w_out_last;

  // Keep only PEs that held a real weight this pass
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NPE; i++) begin
      w_mask[i] = (i < int'(bus.batch_count));
    end
  end

  assign w_hits_m    = bus.batch_hits & w_mask;
  // pend with its lowest set bit removed: next pend after a beat, zero on the last hit
  assign w_pend_rest = r_pend & (r_pend - NPE'(1));
  assign w_accept    = bus.batch_valid && w_batch_ready;
  assign w_beat      = w_out_valid && bus.out_ready;

  // Priority encoder: index of lowest pending hit
  always_comb begin
    w_idx = '0;
    for (int i = NPE - 1; i >= 0; i--) begin
      if (r_pend[i]) w_idx = IXW'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; empty batches never leave IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && (w_hits_m != '0)) w_state_nxt = SCAN;
      SCAN: if (w_beat && w_out_last)         w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state, pend and base
  always_comb begin
    w_batch_ready = 1'b0;
    w_out_valid   = 1'b0;
    w_out_id      = '0;
    w_out_last    = 1'b0;
    case (r_state)
      IDLE: w_batch_ready = 1'b1;
      SCAN: begin
        w_out_valid = 1'b1;
        w_out_id    = r_base + IDW'(w_idx);
        w_out_last  = (w_pend_rest == '0);
      end
      default: w_batch_ready = 1'b0;
    endcase
  end

  // Pending-hit vector and batch base
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_base <= '0;
    end else if (w_accept) begin
      r_pend <= w_hits_m;
      r_base <= bus.batch_base;
    end else if (w_beat) begin
      r_pend <= w_pend_rest;
    end
  end

  // Done pulse (empty accept or last beat) and saturating delivered-ID count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_batch_done <= 1'b0;
      r_hit_total  <= '0;
    end else begin
      r_batch_done <= (w_accept && (w_hits_m == '0)) || (w_beat && w_out_last);
      if (w_beat && (r_hit_total != 16'hFFFF)) r_hit_total <= r_hit_total + 16'd1;
    end
  end

  assign bus.batch_ready = w_batch_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_id      = w_out_id;
  assign bus.out_last    = w_out_last;
  assign bus.batch_done  = r_batch_done;
  assign bus.hit_total   = r_hit_total;

endmodule

// File: tb/tb_match_reporter.sv
// tb_match_reporter: table-driven batches plus hand-written sequences for
// count masking, backpressure, back-to-back batches and reset mid-scan.
module tb_match_reporter;

  logic clk;
  logic reset;

  match_reporter_if bus ();

  match_reporter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [255:0]     hits;
    logic [14:0]      base;
    logic [8:0]       count;
    logic [2:0]       n;
    logic [3:0][14:0] ids;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;
  int exp_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    bus.batch_hits  = {8{$urandom()}};
    bus.batch_base  = 15'($urandom());
    bus.batch_count = 9'($urandom());
  endtask

  // Offer v at the current negedge with out_ready=1 and check every beat.
  task automatic run_batch(input vec_t v, input string tag);
    chk({tag, " ready_before"}, 32'(bus.batch_ready), 1);
    bus.batch_valid = 1'b1;
    bus.batch_hits  = v.hits;
    bus.batch_base  = v.base;
    bus.batch_count = v.count;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    bus.batch_valid = 1'b0;
    scramble_inputs();
    for (int k = 0; k < int'(v.n); k++) begin
      chk({tag, " valid"}, 32'(bus.out_valid), 1);
      chk({tag, " id"}, 32'(bus.out_id), 32'(v.ids[k]));
      chk({tag, " last"}, 32'(bus.out_last), (k == int'(v.n) - 1) ? 1 : 0);
      chk({tag, " done_early"}, 32'(bus.batch_done), 0);
      @(negedge clk);
    end
    exp_total += int'(v.n);
    chk({tag, " valid_after"}, 32'(bus.out_valid), 0);
    chk({tag, " done"}, 32'(bus.batch_done), 1);
    chk({tag, " ready_after"}, 32'(bus.batch_ready), 1);
    chk({tag, " hit_total"}, 32'(bus.hit_total), 32'(exp_total));
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(bus.batch_done), 0);
  endtask

  logic [255:0] h;

  initial begin
    // Vector table: hits, base, count, #IDs, expected IDs (ids[0] first)
    h = '0; h[0] = 1'b1; h[17] = 1'b1; h[255] = 1'b1;
    tbl[0] = '{h, 15'd100, 9'd256, 3'd3, {15'd0, 15'd355, 15'd117, 15'd100}};
    h = '0; h[5] = 1'b1;
    tbl[1] = '{h, 15'd0, 9'd6, 3'd1, {15'd0, 15'd0, 15'd0, 15'd5}};
    h = '0; h[1] = 1'b1; h[2] = 1'b1; h[200] = 1'b1;
    tbl[2] = '{h, 15'd32766, 9'd256, 3'd3, {15'd0, 15'd198, 15'd0, 15'd32767}};
    h = '0; h[3] = 1'b1;
    tbl[3] = '{h, 15'd50, 9'd3, 3'd0, {4{15'd0}}};
    h = '0;
    tbl[4] = '{h, 15'd0, 9'd256, 3'd0, {4{15'd0}}};
    h = '0; h[9] = 1'b1; h[10] = 1'b1; h[11] = 1'b1; h[12] = 1'b1;
    tbl[5] = '{h, 15'd1000, 9'd12, 3'd3, {15'd0, 15'd1011, 15'd1010, 15'd1009}};
    h = '1;
    tbl[6] = '{h, 15'd7, 9'd0, 3'd0, {4{15'd0}}};
    h = '0; h[255] = 1'b1;
    tbl[7] = '{h, 15'd7, 9'd256, 3'd1, {15'd0, 15'd0, 15'd0, 15'd262}};
    h = 256'hF;
    tbl[8] = '{h, 15'd20000, 9'd256, 3'd4, {15'd20003, 15'd20002, 15'd20001, 15'd20000}};

    reset           = 1'b0;
    bus.batch_valid = 1'b0;
    bus.batch_hits  = '0;
    bus.batch_base  = '0;
    bus.batch_count = '0;
    bus.out_ready   = 1'b1;

    // Reset values
    #3;
    chk("rst batch_ready", 32'(bus.batch_ready), 1);
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_id", 32'(bus.out_id), 0);
    chk("rst out_last", 32'(bus.out_last), 0);
    chk("rst batch_done", 32'(bus.batch_done), 0);
    chk("rst hit_total", 32'(bus.hit_total), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_batch(tbl[i], $sformatf("vec%0d", i));
    end

    // Count masking at the top of the weight range
    bus.batch_valid = 1'b1;
    bus.batch_hits  = '1;
    bus.batch_base  = 15'd23296;
    bus.batch_count = 9'd35;
    @(negedge clk);
    bus.batch_valid = 1'b0;
    scramble_inputs();
    for (int k = 0; k < 35; k++) begin
      chk("mask valid", 32'(bus.out_valid), 1);
      chk("mask id", 32'(bus.out_id), 32'(23296 + k));
      chk("mask last", 32'(bus.out_last), (k == 34) ? 1 : 0);
      @(negedge clk);
    end
    exp_total += 35;
    chk("mask valid_after", 32'(bus.out_valid), 0);
    chk("mask done", 32'(bus.batch_done), 1);
    chk("mask hit_total", 32'(bus.hit_total), 32'(exp_total));
    @(negedge clk);

    // Backpressure on hits {3,4}; batch B {0} offered throughout
    bus.batch_valid = 1'b1;
    bus.batch_hits  = 256'h18;
    bus.batch_base  = 15'd40;
    bus.batch_count = 9'd256;
    bus.out_ready   = 1'b0;
    @(negedge clk);
    bus.batch_hits  = 256'h1;
    bus.batch_base  = 15'd500;
    bus.batch_count = 9'd1;
    for (int j = 0; j < 6; j++) begin
      chk("bp valid", 32'(bus.out_valid), 1);
      chk("bp id", 32'(bus.out_id), 43);
      chk("bp last", 32'(bus.out_last), 0);
      chk("bp ready_blocked", 32'(bus.batch_ready), 0);
      bus.out_ready = (j == 5);
      @(negedge clk);
    end
    chk("bp id2", 32'(bus.out_id), 44);
    chk("bp last2", 32'(bus.out_last), 1);
    chk("bp ready_blocked2", 32'(bus.batch_ready), 0);
    @(negedge clk);
    exp_total += 2;
    chk("bp done", 32'(bus.batch_done), 1);
    chk("bp ready_back", 32'(bus.batch_ready), 1);
    chk("bp valid_gap", 32'(bus.out_valid), 0);
    @(negedge clk);
    bus.batch_valid = 1'b0;
    chk("bpB id", 32'(bus.out_id), 500);
    chk("bpB last", 32'(bus.out_last), 1);
    chk("bpB done_clear", 32'(bus.batch_done), 0);
    @(negedge clk);
    exp_total += 1;
    chk("bpB done", 32'(bus.batch_done), 1);
    chk("bpB hit_total", 32'(bus.hit_total), 32'(exp_total));
    @(negedge clk);

    // Back-to-back: A {7} base 10, then B {1,2} base 20 offered continuously
    bus.batch_valid = 1'b1;
    bus.batch_hits  = 256'h80;
    bus.batch_base  = 15'd10;
    bus.batch_count = 9'd256;
    @(negedge clk);
    bus.batch_hits  = 256'h6;
    bus.batch_base  = 15'd20;
    chk("b2b A id", 32'(bus.out_id), 17);
    chk("b2b A last", 32'(bus.out_last), 1);
    @(negedge clk);
    chk("b2b A done", 32'(bus.batch_done), 1);
    chk("b2b B ready", 32'(bus.batch_ready), 1);
    @(negedge clk);
    bus.batch_valid = 1'b0;
    chk("b2b B id0", 32'(bus.out_id), 21);
    chk("b2b B last0", 32'(bus.out_last), 0);
    chk("b2b done_clear", 32'(bus.batch_done), 0);
    @(negedge clk);
    chk("b2b B id1", 32'(bus.out_id), 22);
    chk("b2b B last1", 32'(bus.out_last), 1);
    @(negedge clk);
    exp_total += 3;
    chk("b2b B done", 32'(bus.batch_done), 1);
    chk("b2b hit_total", 32'(bus.hit_total), 32'(exp_total));
    @(negedge clk);

    // Reset during the second beat of a 10-hit batch
    bus.batch_valid = 1'b1;
    bus.batch_hits  = 256'h3FF;
    bus.batch_base  = 15'd0;
    bus.batch_count = 9'd256;
    @(negedge clk);
    bus.batch_valid = 1'b0;
    chk("rms id0", 32'(bus.out_id), 0);
    @(negedge clk);
    chk("rms id1", 32'(bus.out_id), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rms out_valid", 32'(bus.out_valid), 0);
    chk("rms batch_ready", 32'(bus.batch_ready), 1);
    chk("rms out_id", 32'(bus.out_id), 0);
    chk("rms out_last", 32'(bus.out_last), 0);
    chk("rms hit_total", 32'(bus.hit_total), 0);
    chk("rms batch_done", 32'(bus.batch_done), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("rms post valid", 32'(bus.out_valid), 0);
      chk("rms post done", 32'(bus.batch_done), 0);
      chk("rms post ready", 32'(bus.batch_ready), 1);
    end
    exp_total = 0;

    // Fresh batch after reset counts from zero
    h = '0; h[2] = 1'b1;
    run_batch('{h, 15'd300, 9'd256, 3'd1, {15'd0, 15'd0, 15'd0, 15'd302}}, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/match_reporter.md
# match_reporter

Result-side counterpart of the input controller in the string-matching array. Once per matching pass it accepts the full per-PE result vector that the group routers return (`groups*num` bits). It then emits the global weight ID of every PE that reported a match, one ID per accepted beat, on a valid/ready stream. The IDs are produced in ascending PE order, which lets downstream logic consume sparse matches instead of the flat `weight_num`-bit vector.

## Interface
Parameters:
- `groups`, 16: router groups in the array
- `num`, 16: PEs per group
- `NPE`, `groups*num`: result bits per batch
- `weight_num`, 23331: total weights; bounds every emitted ID
- `IDW`, 15: ID width, `clog2(weight_num)`
- `CW`, 9: batch count width, `clog2(NPE+1)`

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `batch_valid`, in, 1: a batch is offered.
- `batch_ready`, out, 1: the block can accept a batch.
- `batch_hits`, in, `NPE`: match bit per PE. Bit i is PE i, where i = group*num + lane.
- `batch_base`, in, `IDW`: weight ID that PE 0 held this pass.
- `batch_count`, in, `CW`: number of PEs holding a real weight (0..`NPE`). Bits at index ≥ count are ignored.
- `out_valid`, out, 1: `out_id` holds a pending match.
- `out_ready`, in, 1: downstream accepts `out_id`.
- `out_id`, out, `IDW`: `batch_base` + PE index of the lowest pending hit.
- `out_last`, out, 1: the current beat is the final hit of its batch.
- `batch_done`, out, 1: one-cycle pulse marking that a batch is fully reported.
- `hit_total`, out, 16: saturating count of IDs delivered since reset.

## Operation
- The state machine has two states, `IDLE` and `SCAN`.
- `batch_ready` = (state == `IDLE`).
- **Accept.** A batch is accepted on a rising edge where `batch_valid` and `batch_ready` are both high. On accept:
  - `pend` ← `batch_hits` AND the mask of bits [0, `batch_count`).
  - `base` ← `batch_base`.
- **Empty batch.** If the masked `pend` is zero, the state stays `IDLE` and `batch_done` pulses the next cycle. No `out_valid` is ever raised for that batch.
- **Non-empty batch.** If the masked `pend` is nonzero, the state goes to `SCAN`.
- **Output in `SCAN`:**
  - `out_valid` = 1.
  - idx = lowest set bit of `pend`, from a priority encoder.
  - `out_id` = `base` + idx, truncated to `IDW` bits.
  - `out_last` = 1 when `pend` has exactly one set bit.
- **Handshake beat** (`out_valid` and `out_ready` both high):
  - Clear bit idx of `pend`.
  - `hit_total` increments and saturates at 16'hFFFF.
  - On the `out_last` beat, the state returns to `IDLE` and `batch_done` pulses the following cycle.
- **Stall.** While `out_ready` = 0 in `SCAN`, `out_id`, `out_last` and `pend` hold stable and `out_valid` stays 1. Valid is never withdrawn once raised.
- **Caller contract.** The caller guarantees `batch_base` + `batch_count` ≤ `weight_num`. The block does not check this; `out_id` simply wraps modulo 2^`IDW`.
- **Input stability.** `batch_hits`, `batch_base` and `batch_count` are sampled only on accept. Changes at other times have no effect.

## Timing
- **Reset values.** While `reset` is low, all of the following are forced asynchronously:
  - state = `IDLE`, `pend` = 0, `base` = 0
  - `batch_ready` = 1, `out_valid` = 0, `out_id` = 0, `out_last` = 0
  - `batch_done` = 0, `hit_total` = 0
- **Reset mid-`SCAN`.** Pending hits are discarded. No `batch_done` is produced for that batch.
- **Latency.** For a batch accepted on edge N, `out_valid` is high in the cycle after edge N.
- **Throughput.** One ID per cycle while `out_ready` = 1. A batch with k hits (k ≥ 1) occupies k cycles in `SCAN`.
- **Batch-to-batch gap.** `batch_ready` returns high in the cycle after the `out_last` handshake. A new batch may be accepted on that same cycle's edge, so the minimum gap between batches is one cycle.
- **Overlapping events.** `batch_done` for the previous batch and the accept of the next batch may coincide, and both take effect.
- **`batch_done` source.** `batch_done` is registered: exactly one high cycle per completed batch, and never high during reset.
- **Combinational paths.** The only combinational input-to-output paths are none; `out_*` depend only on registered `pend` and `base`.
- **Critical path.** The `NPE`-bit priority encoder plus the `IDW` adder. It must close at the array clock.

## Test plan
- **Basic ordering.** Batch with base=100, count=256, hits at bits {0, 17, 255}, `out_ready`=1 → `out_id` 100, 117, 355 on three consecutive cycles. `out_last` is high on 355 only, `batch_done` pulses one cycle later, and `hit_total`=3.
- **Count masking.** Batch with base=23296, count=35, all 256 hits set → IDs 23296..23330 (35 beats), `out_last` on 23330, and nothing emitted at or above `weight_num`.
- **Empty batch.** Batch with hits=0, or with hits only above count → no `out_valid`, `batch_ready` stays 1, and `batch_done` pulses on the cycle after accept.
- **Backpressure.** Hits {3, 4}, with `out_ready` low for 5 cycles after `out_valid` rises → `out_id`=base+3 is held stable for 6 cycles, then base+4 follows. `batch_valid` offered during this period is not accepted until `out_last` completes.
- **Back-to-back batches.** Batch A (hit {7}) is followed by batch B offered continuously → B is accepted on the cycle after A's last beat. A's `batch_done` and B's accept coincide, and B's first ID appears one cycle later.
- **Reset mid-scan.** Drop `reset` low asynchronously mid-cycle during the second beat of a 10-hit batch → outputs clear immediately and `hit_total`=0. After release, `batch_ready`=1 and no stale IDs appear.
